counter_display: RTL and testbench
==================================

# counter_display

Display stage that sits directly downstream of the lab 2 up/down counter (0..12 saturating, load, enable, direction). It takes the 4-bit count plus the counter's control inputs and drives a 4-digit, common-anode, time-multiplexed seven-segment display. Its outputs are the two decimal digits of the count, a blank digit, and a status glyph. The count is snapshotted once per scan frame, so a digit never tears mid-frame.

## Interface
- REFRESH_DIV, default 131072: clock cycles each digit stays lit (≥2). 131072 gives about 190 Hz per frame at 100 MHz.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- count  input  4  counter output; legal range 0..12
- en  input  1  counter enable, used for the status glyph
- load  input  1  counter load, used for the status glyph
- dir  input  1  counter direction: 1 = up, 0 = down
- an  output  4  digit anodes, active-low, one-hot-low when active
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; always 1 (off)

## Operation
- Divider `div_cnt`:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - `tick` is high on the cycle where div_cnt = REFRESH_DIV-1.
- Scan index `idx` (2 bits): increments mod 4 on `tick`. Digit order per frame is idx 0, 1, 2, 3.
- Snapshot registers `snap_cnt[3:0]` and `snap_st[1:0]`:
  - Loaded on the cycle where `tick` is high and idx = 3 (frame boundary).
  - Hold their value at all other times.
- Status code `snap_st`, first match wins:
  - count > 12 → ERR
  - en=1 & load=1 → LOAD
  - en=0 → PAUSE
  - dir=1 → UP
  - otherwise → DOWN
- Digit content by idx, using snap_cnt (0..12) → tens/ones:
  - idx 0 (an=1110): ones digit.
  - idx 1 (an=1101): tens digit; blank when tens = 0 (leading-zero suppression).
  - idx 2 (an=1011): always blank.
  - idx 3 (an=0111): status glyph: UP 'U', DOWN 'd', PAUSE '-', LOAD 'L', ERR 'E'.
  - When status is ERR, idx 0 and idx 1 are both blank.
- Segment codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - U=1000001, d=0100001, -=0111111, L=1000111, E=0000110, blank=1111111
- an and seg are registered. They show the decode of the idx value and snapshot from the previous cycle.

## Timing
- Reset (rst=0), asynchronous:
  - div_cnt=0, idx=0, snap_cnt=0, snap_st=PAUSE.
  - an=1111, seg=1111111, dp=1.
- Reset is honoured at any point, including mid-digit or mid-frame. Scanning restarts from idx 0, div_cnt 0.
- First rising edge after release: an=1110, seg=1000000 ('0').
- Each digit is active for exactly REFRESH_DIV cycles. A frame is 4·REFRESH_DIV cycles.
- The anode change lags the idx change by one cycle. There is no blanking gap between digits.
- Snapshot latency:
  - An input change becomes visible at the start of the next frame after the next frame boundary.
  - Minimum latency is 1 cycle; maximum is 4·REFRESH_DIV+1 cycles.
- Inputs that change within a frame have no effect until the frame boundary. Only the values on the boundary cycle are sampled.
- Counter wrap-around is irrelevant here; any value 13..15 is reported as ERR.

## Structure
- Package `counter_display_pkg` holds:
  - the segment code constants (digits 0-9, U, d, -, L, E, blank);
  - the status enum {UP, DOWN, PAUSE, LOAD, ERR};
  - NUM_DIGITS=4 and the anode one-hot constants.
- Sub-module `seg_decoder`: combinational map from a 5-bit symbol code to seg[6:0].
- Top-level content: divider, idx, snapshot, binary-to-two-digit split (value ≥ 10 → tens=1, ones=value-10), and output registers.

## Test plan
All scenarios use REFRESH_DIV=4 (frame = 16 cycles).
- Reset:
  - Hold rst=0 → an=1111, seg=1111111, dp=1.
  - Release → next edge an=1110, seg=1000000; after 4 cycles an=1101.
- Count 12, en=1, dir=1, stable over 2 frames → digit0 '2' (0100100), digit1 '1' (1111001), digit2 blank, digit3 'U' (1000001).
- Count 5, en=0 → digit1 blank (leading zero), digit0 '5' (0010010), digit3 '-' (0111111).
- Count 3, en=1, load=1 → digit3 'L' (1000111); then dir=0, load=0 → 'd' (0100001) after the next frame boundary.
- Count 14 → digit3 'E' (0000110), digits 0 and 1 blank.
- Snapshot and mid-frame reset:
  - Change count 7→9 while idx=1 → the '7' frame completes unchanged; '9' appears from the next frame's idx 0.
  - Assert rst mid-digit → outputs immediately go to 1111/1111111.

Source files
------------

// File: rtl/counter_display_pkg.sv
// counter_display_pkg: symbol codes, segment patterns, status enum, anode and status helpers for counter_display
package counter_display_pkg;
  localparam int NUM_DIGITS = 4;
  typedef enum logic [2:0] {ST_UP, ST_DOWN, ST_PAUSE, ST_LOAD, ST_ERR} status_t;
  localparam logic [4:0] SYM_U     = 5'd10;
  localparam logic [4:0] SYM_D     = 5'd11;
  localparam logic [4:0] SYM_DASH  = 5'd12;
  localparam logic [4:0] SYM_L     = 5'd13;
  localparam logic [4:0] SYM_E     = 5'd14;
  localparam logic [4:0] SYM_BLANK = 5'd15;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [3:0] AN_0      = 4'b1110;
  localparam logic [3:0] AN_1      = 4'b1101;
  localparam logic [3:0] AN_2      = 4'b1011;
  localparam logic [3:0] AN_3      = 4'b0111;
  function automatic logic [3:0] anode(input logic [1:0] i);
    return i == 2'd0 ? AN_0 : i == 2'd1 ? AN_1 : i == 2'd2 ? AN_2 : AN_3;
  endfunction
  function automatic status_t status_of(input logic [3:0] c, input logic e, input logic l, input logic d);
    return c > 4'd12 ? ST_ERR : (e && l) ? ST_LOAD : !e ? ST_PAUSE : d ? ST_UP : ST_DOWN;
  endfunction
  function automatic logic [4:0] glyph_sym(input status_t s);
    return s == ST_UP ? SYM_U : s == ST_DOWN ? SYM_D : s == ST_PAUSE ? SYM_DASH :
           s == ST_LOAD ? SYM_L : SYM_E;
  endfunction
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: 5-bit symbol code (0-9, U, d, -, L, E, blank) to active-low segments {g..a}; in sym, out seg
module seg_decoder
  import counter_display_pkg::*;
(
  input  logic [4:0] sym,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (sym)
      5'd0:     seg = SEG_0;
      5'd1:     seg = SEG_1;
      5'd2:     seg = SEG_2;
      5'd3:     seg = SEG_3;
      5'd4:     seg = SEG_4;
      5'd5:     seg = SEG_5;
      5'd6:     seg = SEG_6;
      5'd7:     seg = SEG_7;
      5'd8:     seg = SEG_8;
      5'd9:     seg = SEG_9;
      SYM_U:    seg = SEG_U;
      SYM_D:    seg = SEG_D;
      SYM_DASH: seg = SEG_DASH;
      SYM_L:    seg = SEG_L;
      SYM_E:    seg = SEG_E;
      default:  seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/counter_display.sv
// counter_display: 4-digit muxed 7-seg view of a 0..12 counter; in clk, rst (async active-low), count, en, load, dir; out an, seg, dp (all active-low)
module counter_display
  import counter_display_pkg::*;
#(
  parameter int REFRESH_DIV = 131072
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  input  logic       en,
  input  logic       load,
  input  logic       dir,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int DW = $clog2(REFRESH_DIV);
  logic [DW-1:0] div_cnt;
  logic [1:0]    idx;
  logic [3:0]    snap_cnt;
  status_t       snap_st;
  logic          tick;
  logic          tens;
  logic          err;
  logic [3:0]    ones;
  logic [4:0]    sym;
  logic [6:0]    seg_d;
  assign tick = div_cnt == DW'(REFRESH_DIV - 1);
  assign tens = snap_cnt >= 4'd10;
  assign ones = tens ? snap_cnt - 4'd10 : snap_cnt;
  assign err  = snap_st == ST_ERR;
  assign dp   = 1'b1;
  always_comb
    sym = idx == 2'd0 ? (err ? SYM_BLANK : {1'b0, ones}) :
          idx == 2'd1 ? ((err || !tens) ? SYM_BLANK : 5'd1) :
          idx == 2'd2 ? SYM_BLANK : glyph_sym(snap_st);
  seg_decoder u_dec (
    .sym (sym),
    .seg (seg_d)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div_cnt  <= '0;
      idx      <= 2'd0;
      snap_cnt <= 4'd0;
      snap_st  <= ST_PAUSE;
      an       <= AN_OFF;
      seg      <= SEG_BLANK;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) idx <= idx + 2'd1;
      // frame boundary: sample only here so a frame never mixes two counts
      if (tick && idx == 2'd3) begin
        snap_cnt <= count;
        snap_st  <= status_of(count, en, load, dir);
      end
      an  <= anode(idx);
      seg <= seg_d;
    end
endmodule

// File: tb/tb_counter_display.sv
// tb_counter_display: vector table, corner sequences and random stimulus against a frame-level model
module tb_counter_display;
  localparam int R = 4;
  localparam int F = 4 * R;
  localparam logic [6:0] BL = 7'b1111111;
  typedef struct {
    logic [3:0] c;
    logic e, l, d;
    logic [6:0] d0, d1, d3;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] count = 4'd0;
  logic en = 1'b0, load = 1'b0, dir = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  int tests = 0, fails = 0, n = 0, snap_c = 0, snap_s = 2;
  logic [6:0] digs [10];
  logic [6:0] glyph [5];
  vec_t vt [7];
  logic [6:0] cap [4];
  counter_display #(.REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .count(count), .en(en), .load(load), .dir(dir),
    .an(an), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s n=%0d got=%b want=%b", name, n, act, exp);
    end
  endtask
  function automatic int st(input int c, input logic e, input logic l, input logic d);
    if (c > 12) return 4;
    if (e && l) return 3;
    if (!e) return 2;
    if (d) return 0;
    return 1;
  endfunction
  function automatic logic [6:0] exp_seg(input int i);
    if (i == 2) return BL;
    if (i == 3) return glyph[snap_s];
    if (snap_s == 4) return BL;
    if (i == 0) return digs[snap_c % 10];
    return snap_c < 10 ? BL : digs[snap_c / 10];
  endfunction
  task automatic tick_check();
    int i;
    logic [6:0] es;
    logic [3:0] ea;
    @(posedge clk);
    n++;
    i = ((n - 1) / R) % 4;
    es = exp_seg(i);
    ea = ~(4'b0001 << i);
    if (n % F == 0) begin
      snap_c = int'(count);
      snap_s = st(int'(count), en, load, dir);
    end
    #1;
    check("an", {28'd0, an}, {28'd0, ea});
    check("seg", {25'd0, seg}, {25'd0, es});
    check("dp", {31'd0, dp}, 32'd1);
  endtask
  task automatic to_boundary();
    do tick_check(); while (n % F != 0);
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    snap_c = 0;
    snap_s = 2;
  endtask
  initial begin
    digs = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    glyph = '{7'b1000001, 7'b0100001, 7'b0111111, 7'b1000111, 7'b0000110};
    vt[0] = '{4'd12, 1'b1, 1'b0, 1'b1, 7'b0100100, 7'b1111001, 7'b1000001};
    vt[1] = '{4'd5,  1'b0, 1'b0, 1'b1, 7'b0010010, BL,         7'b0111111};
    vt[2] = '{4'd3,  1'b1, 1'b1, 1'b1, 7'b0110000, BL,         7'b1000111};
    vt[3] = '{4'd3,  1'b1, 1'b0, 1'b0, 7'b0110000, BL,         7'b0100001};
    vt[4] = '{4'd14, 1'b1, 1'b0, 1'b1, BL,         BL,         7'b0000110};
    vt[5] = '{4'd10, 1'b1, 1'b0, 1'b0, 7'b1000000, 7'b1111001, 7'b0100001};
    vt[6] = '{4'd0,  1'b1, 1'b0, 1'b1, 7'b1000000, BL,         7'b1000001};
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", {28'd0, an}, 32'b1111);
    check("rst_seg", {25'd0, seg}, 32'b1111111);
    check("rst_dp", {31'd0, dp}, 32'd1);
    release_rst();
    tick_check();
    check("first_an", {28'd0, an}, 32'b1110);
    check("first_seg", {25'd0, seg}, 32'b1000000);
    repeat (R) tick_check();
    check("second_an", {28'd0, an}, 32'b1101);
    for (int v = 0; v < 7; v++) begin
      count = vt[v].c;
      en = vt[v].e;
      load = vt[v].l;
      dir = vt[v].d;
      to_boundary();
      for (int k = 0; k < F; k++) begin
        tick_check();
        for (int j = 0; j < 4; j++) if (an == ~(4'b0001 << j)) cap[j] = seg;
      end
      check($sformatf("vec%0d_d0", v), {25'd0, cap[0]}, {25'd0, vt[v].d0});
      check($sformatf("vec%0d_d1", v), {25'd0, cap[1]}, {25'd0, vt[v].d1});
      check($sformatf("vec%0d_d2", v), {25'd0, cap[2]}, {25'd0, BL});
      check($sformatf("vec%0d_d3", v), {25'd0, cap[3]}, {25'd0, vt[v].d3});
    end
    count = 4'd7;
    en = 1'b1;
    load = 1'b0;
    dir = 1'b1;
    to_boundary();
    tick_check();
    check("seq7_d0", {25'd0, seg}, 32'b1111000);
    repeat (R) tick_check();
    count = 4'd9;
    to_boundary();
    check("seq7_tail_d3", {25'd0, seg}, 32'b1000001);
    tick_check();
    check("seq9_an", {28'd0, an}, 32'b1110);
    check("seq9_d0", {25'd0, seg}, 32'b0010000);
    repeat (6) tick_check();
    #2 rst = 1'b0;
    #1;
    check("midrst_an", {28'd0, an}, 32'b1111);
    check("midrst_seg", {25'd0, seg}, 32'b1111111);
    check("midrst_dp", {31'd0, dp}, 32'd1);
    release_rst();
    tick_check();
    check("restart_an", {28'd0, an}, 32'b1110);
    check("restart_seg", {25'd0, seg}, 32'b1000000);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        count = 4'($urandom_range(0, 15));
        en = 1'($urandom_range(0, 1));
        load = 1'($urandom_range(0, 1));
        dir = 1'($urandom_range(0, 1));
      end
      tick_check();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
